dds_sweep_ctrl: RTL and testbench

//  Sequencer for the DDS core. Drives its 12-bit frequency/phase word (phase_data) and waveform select (mux).
//  On a start pulse it steps phase_data from a start word to a stop word in fixed increments.

---
 rtl/dds_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency/phase sweep sequencer feeding dds_top: steps phase_data from start_word to stop_word.
// Optional macro DDS_SWEEP_LOOP_EN makes the sweep restart continuously instead of finishing.
module dds_sweep_ctrl #(
   parameter int PHASE_W = 12,
   parameter int DWELL_W = 16
) (
   input  logic               clk_50MHz,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [PHASE_W-1:0] start_word,
   input  logic [PHASE_W-1:0] stop_word,
   input  logic [PHASE_W-1:0] step_word,
   input  logic [DWELL_W-1:0] dwell_len,
   input  logic [1:0]         wave_sel,
   output logic [PHASE_W-1:0] phase_data,
   output logic [1:0]         mux,
   output logic               busy,
   output logic               step_tick,
   output logic               sweep_done,
   output logic               cfg_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [PHASE_W-1:0] stop_q;
   logic [PHASE_W-1:0] step_q;
`ifdef DDS_SWEEP_LOOP_EN
   logic [PHASE_W-1:0] start_q;
`endif
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DWELL_W-1:0] dwell_eff;
   logic [PHASE_W:0]   next_word;
   logic               cfg_ok;
   logic               next_fits;
   logic               last_dwell;

   // The extra top bit of next_word catches carry-out so the sweep never wraps past full scale.
   assign cfg_ok     = (step_word != '0) && (start_word <= stop_word);
   assign dwell_eff  = (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
   assign next_word  = {1'b0, phase_data} + {1'b0, step_q};
   assign next_fits  = (next_word <= {1'b0, stop_q});
   assign last_dwell = (dwell_cnt == DWELL_W'(1));

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state      <= IDLE;
         phase_data <= '0;
         mux        <= '0;
         busy       <= 1'b0;
         step_tick  <= 1'b0;
         sweep_done <= 1'b0;
         cfg_err    <= 1'b0;
         stop_q     <= '0;
         step_q     <= '0;
`ifdef DDS_SWEEP_LOOP_EN
         start_q    <= '0;
`endif
         dwell_q    <= '0;
         dwell_cnt  <= '0;
      end else begin
         step_tick  <= 1'b0;
         sweep_done <= 1'b0;
         cfg_err    <= 1'b0;

         // Abort outranks everything else, including a start arriving in the same cycle.
         if (abort && (state != IDLE)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            phase_data <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     if (cfg_ok) begin
                        phase_data <= start_word;
                        mux        <= wave_sel;
                        busy       <= 1'b1;
                        stop_q     <= stop_word;
                        step_q     <= step_word;
`ifdef DDS_SWEEP_LOOP_EN
                        start_q    <= start_word;
`endif
                        dwell_q    <= dwell_eff;
                        dwell_cnt  <= dwell_eff;
                        state      <= DWELL;
                     end else begin
                        cfg_err <= 1'b1;
                     end
                  end
               end

               DWELL: begin
                  if (last_dwell) begin
                     dwell_cnt <= dwell_q;
                     if (next_fits) begin
                        phase_data <= next_word[PHASE_W-1:0];
                        step_tick  <= 1'b1;
                     end else begin
`ifdef DDS_SWEEP_LOOP_EN
                        phase_data <= start_q;
                        step_tick  <= 1'b1;
                        sweep_done <= 1'b1;
`else
                        state      <= DONE;
                        busy       <= 1'b0;
                        sweep_done <= 1'b1;
`endif
                     end
                  end else begin
                     dwell_cnt <= dwell_cnt - DWELL_W'(1);
                  end
               end

               DONE: begin
                  state <= IDLE;
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed scoreboard bench for dds_sweep_ctrl; expected outputs are queued per cycle and popped after each edge.
// Build with DDS_SWEEP_LOOP_EN defined to exercise the continuous-sweep variant.
module tb_dds_sweep_ctrl;

   logic        clk_50MHz;
   logic        reset;
   logic        start;
   logic        abort;
   logic [11:0] start_word;
   logic [11:0] stop_word;
   logic [11:0] step_word;
   logic [15:0] dwell_len;
   logic [1:0]  wave_sel;
   logic [11:0] phase_data;
   logic [1:0]  mux;
   logic        busy;
   logic        step_tick;
   logic        sweep_done;
   logic        cfg_err;

   typedef struct packed {
      logic [11:0] phase;
      logic [1:0]  mux;
      logic        busy;
      logic        tick;
      logic        done;
      logic        err;
   } exp_t;

   exp_t  score_q[$];
   string tag_q[$];
   int    errors = 0;
   int    checks = 0;

   dds_sweep_ctrl #(.PHASE_W(12), .DWELL_W(16)) dut (
      .clk_50MHz  (clk_50MHz),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .start_word (start_word),
      .stop_word  (stop_word),
      .step_word  (step_word),
      .dwell_len  (dwell_len),
      .wave_sel   (wave_sel),
      .phase_data (phase_data),
      .mux        (mux),
      .busy       (busy),
      .step_tick  (step_tick),
      .sweep_done (sweep_done),
      .cfg_err    (cfg_err)
   );

   initial begin
      clk_50MHz = 1'b0;
      forever #10 clk_50MHz = ~clk_50MHz;
   end

   task automatic set_cfg(input logic [11:0] sw, input logic [11:0] pw, input logic [11:0] st,
                          input logic [15:0] dw, input logic [1:0] ws);
      start_word = sw;
      stop_word  = pw;
      step_word  = st;
      dwell_len  = dw;
      wave_sel   = ws;
   endtask

   task automatic applyStimulus(input logic st, input logic ab);
      start = st;
      abort = ab;
   endtask

   task automatic expectOut(input string tag, input logic [11:0] ph, input logic [1:0] mx,
                            input logic b, input logic t, input logic d, input logic e);
      exp_t x;
      x.phase = ph;
      x.mux   = mx;
      x.busy  = b;
      x.tick  = t;
      x.done  = d;
      x.err   = e;
      score_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   task automatic check_field(input string tag, input string name, input logic [11:0] obs,
                              input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s %s observed=%0h expected=%0h", tag, name, obs, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t  x;
      string tag;
      if (score_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1 entries");
      end else begin
         x   = score_q.pop_front();
         tag = tag_q.pop_front();
         check_field(tag, "phase_data", phase_data, x.phase);
         check_field(tag, "mux", 12'(mux), 12'(x.mux));
         check_field(tag, "busy", 12'(busy), 12'(x.busy));
         check_field(tag, "step_tick", 12'(step_tick), 12'(x.tick));
         check_field(tag, "sweep_done", 12'(sweep_done), 12'(x.done));
         check_field(tag, "cfg_err", 12'(cfg_err), 12'(x.err));
      end
   endtask

   task automatic cycle();
      @(posedge clk_50MHz);
      #1;
      checkOutput();
   endtask

   initial begin
      logic [11:0] w;
      logic        t;
      logic        d;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      set_cfg(12'h000, 12'h000, 12'h000, 16'd0, 2'b00);

      $display("[TB] reset and idle");
      for (int i = 0; i < 2; i++) begin
         expectOut("reset", 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         expectOut("idle", 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         cycle();
      end

      $display("[TB] bad configurations");
      set_cfg(12'h100, 12'h1FF, 12'h000, 16'd4, 2'b11);
      applyStimulus(1'b1, 1'b0);
      expectOut("bad_step", 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      applyStimulus(1'b0, 1'b0);
      expectOut("bad_step_after", 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      set_cfg(12'h100, 12'h0FF, 12'h010, 16'd4, 2'b11);
      applyStimulus(1'b1, 1'b0);
      expectOut("bad_order", 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      applyStimulus(1'b0, 1'b0);
      expectOut("bad_order_after", 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();

      $display("[TB] start with abort in idle");
      set_cfg(12'h010, 12'h040, 12'h010, 16'd4, 2'b01);
      applyStimulus(1'b1, 1'b1);
      expectOut("start_abort", 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0);
         expectOut("start_abort_idle", 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
         cycle();
      end

`ifndef DDS_SWEEP_LOOP_EN
      $display("[TB] basic sweep");
      for (int c = 1; c <= 18; c++) begin
         applyStimulus(c == 1 || c == 10, 1'b0);
         step_word = (c == 10) ? 12'h000 : 12'h010;
         if (c <= 16) begin
            w = 12'h010 + 12'(((c - 1) / 4) * 16);
            t = (c > 1) && ((c - 1) % 4 == 0);
            expectOut("sweep", w, 2'b01, 1'b1, t, 1'b0, 1'b0);
         end else begin
            expectOut("sweep_end", 12'h040, 2'b01, 1'b0, 1'b0, c == 17, 1'b0);
         end
         cycle();
      end

      $display("[TB] carry stop");
      set_cfg(12'hFF0, 12'hFFF, 12'h008, 16'd0, 2'b10);
      applyStimulus(1'b1, 1'b0);
      expectOut("carry_c1", 12'hFF0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      applyStimulus(1'b0, 1'b0);
      expectOut("carry_c2", 12'hFF8, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle();
      expectOut("carry_c3", 12'hFF8, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      expectOut("carry_c4", 12'hFF8, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();

      $display("[TB] abort mid-sweep");
      set_cfg(12'h010, 12'h040, 12'h010, 16'd4, 2'b01);
      for (int c = 1; c <= 10; c++) begin
         applyStimulus(c == 1, c == 8);
         if (c <= 7) begin
            w = 12'h010 + 12'(((c - 1) / 4) * 16);
            t = (c > 1) && ((c - 1) % 4 == 0);
            expectOut("abort_run", w, 2'b01, 1'b1, t, 1'b0, 1'b0);
         end else begin
            expectOut("abort_after", 12'h000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         cycle();
      end
`else
      $display("[TB] looping sweep");
      for (int c = 1; c <= 42; c++) begin
         applyStimulus(c == 1 || c == 20, c == 41);
         if (c <= 40) begin
            w = 12'h010 + 12'((((c - 1) % 16) / 4) * 16);
            t = (c > 1) && ((c - 1) % 4 == 0);
            d = (c > 1) && ((c - 1) % 16 == 0);
            expectOut("loop", w, 2'b01, 1'b1, t, d, 1'b0);
         end else begin
            expectOut("loop_abort", 12'h000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         cycle();
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
